pi_ti_shift_latch: RTL and testbench

- Upstream feeder for the 8-bit TI data-bus tristate stage.
- Receives bytes from the Raspberry Pi over the serial shift interface (r_clk/r_din/r_le/r_rt) and holds them in the TD (data) and TC (control) registers.
- When the TI reads TD or TC, it presents the selected register on tri_i and asserts tri_t. The downstream tristate stage drives the TI bus only while tri_t=1.

---
 rtl/pi_ti_shift_latch.sv | 175 +++++++++++++++++
 tb/tb_pi_ti_shift_latch.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pi_ti_shift_latch.sv
// Serial-to-parallel feeder for the TI data-bus tristate stage: bytes shifted in
// from the Pi land in TD or TC, and the TI read selects route one of them to the bus.
module pi_ti_shift_latch #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             r_clk,
  input  logic             r_din,
  input  logic             r_le,
  input  logic             r_rt,
  input  logic             ti_rd_td,
  input  logic             ti_rd_tc,
  output logic             tri_t,
  output logic [WIDTH-1:0] tri_i,
  output logic [WIDTH-1:0] td_q,
  output logic [WIDTH-1:0] tc_q,
  output logic             latch_pulse,
  output logic             frame_err
);

  // The counter must be able to hold WIDTH+1, the saturation value.
  localparam int                CNT_W    = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(WIDTH + 1);
  localparam int                TOP      = SYNC_STAGES - 1;

  // ---------------------------------------------------------------------------
  // Synchronizers for the four asynchronous Pi pins
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic [SYNC_STAGES-1:0] le_sync_q;
  logic [SYNC_STAGES-1:0] rt_sync_q;

  // NOTE: sequential state is always written with <= so every flop samples the
  // pre-edge value of its neighbours; blocking '=' here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync_q <= '0;
      din_sync_q <= '0;
      le_sync_q  <= '0;
      rt_sync_q  <= '0;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], r_clk};
      din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], r_din};
      le_sync_q  <= {le_sync_q[SYNC_STAGES-2:0],  r_le};
      rt_sync_q  <= {rt_sync_q[SYNC_STAGES-2:0],  r_rt};
    end
  end

  // ---------------------------------------------------------------------------
  // Registered edge detection; data and target are delayed alongside so they
  // stay aligned with the strobes they qualify.
  // ---------------------------------------------------------------------------
  logic clk_prev_q, le_prev_q;
  logic clk_rise_q, le_rise_q;
  logic din_q, rt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_prev_q <= 1'b0;
      le_prev_q  <= 1'b0;
      clk_rise_q <= 1'b0;
      le_rise_q  <= 1'b0;
      din_q      <= 1'b0;
      rt_q       <= 1'b0;
    end else begin
      clk_prev_q <= clk_sync_q[TOP];
      le_prev_q  <= le_sync_q[TOP];
      clk_rise_q <= clk_sync_q[TOP] & ~clk_prev_q;
      le_rise_q  <= le_sync_q[TOP] & ~le_prev_q;
      din_q      <= din_sync_q[TOP];
      rt_q       <= rt_sync_q[TOP];
    end
  end

  // ---------------------------------------------------------------------------
  // Shift register, bit counter and commit into TD/TC
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] td_d, tc_d;
  logic             pulse_d, err_d;
  logic             latch_pulse_q, frame_err_q;

  // NOTE: every always_comb output gets a default before any branch; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    td_d    = td_q;
    tc_d    = tc_q;
    pulse_d = 1'b0;
    err_d   = frame_err_q;

    // Shift first so a latch in the same cycle sees the post-shift word and count.
    if (clk_rise_q) begin
      shift_d = {shift_q[WIDTH-2:0], din_q};
      if (cnt_q != CNT_SAT) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    if (le_rise_q) begin
      if (cnt_d == CNT_FULL) begin
        if (rt_q) begin
          tc_d = shift_d;
        end else begin
          td_d = shift_d;
        end
        pulse_d = 1'b1;
        err_d   = 1'b0;
      end else begin
        err_d = 1'b1;
      end
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q       <= '0;
      cnt_q         <= '0;
      td_q          <= '0;
      tc_q          <= '0;
      latch_pulse_q <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      td_q          <= td_d;
      tc_q          <= tc_d;
      latch_pulse_q <= pulse_d;
      frame_err_q   <= err_d;
    end
  end

  assign latch_pulse = latch_pulse_q;
  assign frame_err   = frame_err_q;

  // ---------------------------------------------------------------------------
  // TI read path: registered mux; both selects high is treated as no read so
  // the bus is never contended.
  // ---------------------------------------------------------------------------
  logic             tri_t_q, tri_t_d;
  logic [WIDTH-1:0] tri_i_q, tri_i_d;

  always_comb begin
    tri_t_d = 1'b0;
    tri_i_d = '0;
    if (ti_rd_td && !ti_rd_tc) begin
      tri_t_d = 1'b1;
      tri_i_d = td_q;
    end else if (ti_rd_tc && !ti_rd_td) begin
      tri_t_d = 1'b1;
      tri_i_d = tc_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tri_t_q <= 1'b0;
      tri_i_q <= '0;
    end else begin
      tri_t_q <= tri_t_d;
      tri_i_q <= tri_i_d;
    end
  end

  assign tri_t = tri_t_q;
  assign tri_i = tri_i_q;

endmodule

// File: tb/tb_pi_ti_shift_latch.sv
// Directed bench for pi_ti_shift_latch: Pi frames are bit-banged with phases well
// above the synchronizer contract and all outputs are compared on the falling clk edge.
module tb_pi_ti_shift_latch;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             r_clk = 1'b0, r_din = 1'b0, r_le = 1'b0, r_rt = 1'b0;
  logic             ti_rd_td = 1'b0, ti_rd_tc = 1'b0;
  logic             tri_t;
  logic [WIDTH-1:0] tri_i, td_q, tc_q;
  logic             latch_pulse, frame_err;

  int n_cmp  = 0;
  int n_fail = 0;

  pi_ti_shift_latch #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .r_clk      (r_clk),
    .r_din      (r_din),
    .r_le       (r_le),
    .r_rt       (r_rt),
    .ti_rd_td   (ti_rd_td),
    .ti_rd_tc   (ti_rd_tc),
    .tri_t      (tri_t),
    .tri_i      (tri_i),
    .td_q       (td_q),
    .tc_q       (tc_q),
    .latch_pulse(latch_pulse),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  // Falling-edge monitor: pulse count and run length, last-change cycles, tri_t lows.
  int             cyc = 0;
  int             pulse_cnt = 0, pulse_run = 0, pulse_max_run = 0;
  int             td_chg = 0, tri_chg = 0, tri_low = 0;
  logic [WIDTH-1:0] td_prev = '0, tri_prev = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (latch_pulse === 1'b1) begin
      pulse_cnt <= pulse_cnt + 1;
      pulse_run <= pulse_run + 1;
      if (pulse_run + 1 > pulse_max_run) pulse_max_run <= pulse_run + 1;
    end else begin
      pulse_run <= 0;
    end
    if (td_q !== td_prev) td_chg <= cyc;
    if (tri_i !== tri_prev) tri_chg <= cyc;
    if (tri_t !== 1'b1) tri_low <= tri_low + 1;
    td_prev  <= td_q;
    tri_prev <= tri_i;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Each Pi phase lasts 5 clk cycles, above the 4-cycle minimum.
  task automatic pi_bit(input logic b);
    r_din = b;
    wait_cyc(5);
    r_clk = 1'b1;
    wait_cyc(5);
    r_clk = 1'b0;
    wait_cyc(5);
  endtask

  task automatic send_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) pi_bit(v[i]);
  endtask

  task automatic pi_latch(input logic rt);
    r_rt = rt;
    wait_cyc(5);
    r_le = 1'b1;
    wait_cyc(5);
    r_le = 1'b0;
    wait_cyc(5);
  endtask

  int p0, p1, low0, low1;

  initial begin
    // 1. Reset, idle, one-cycle TD read of an empty register
    wait_cyc(3);
    reset_n = 1'b1;
    wait_cyc(10);
    check("idle_tri_t", tri_t, 0);
    check("idle_tri_i", tri_i, 8'h00);
    check("idle_td", td_q, 8'h00);
    check("idle_tc", tc_q, 8'h00);
    check("idle_pulse", latch_pulse, 0);
    check("idle_err", frame_err, 0);
    ti_rd_td = 1'b1;
    wait_cyc(1);
    ti_rd_td = 1'b0;
    check("rd_empty_tri_t", tri_t, 1);
    check("rd_empty_tri_i", tri_i, 8'h00);
    wait_cyc(1);
    check("rd_empty_release", tri_t, 0);

    // 2. A5 to TD
    p0 = pulse_cnt;
    send_bits(16'h00A5, 8);
    pi_latch(1'b0);
    check("a5_pulse_count", pulse_cnt - p0, 1);
    check("a5_td", td_q, 8'hA5);
    check("a5_tc", tc_q, 8'h00);
    check("a5_err", frame_err, 0);
    ti_rd_td = 1'b1;
    check("a5_rd_latency", tri_t, 0);
    wait_cyc(1);
    check("a5_rd_tri_t", tri_t, 1);
    check("a5_rd_tri_i", tri_i, 8'hA5);
    ti_rd_td = 1'b0;
    wait_cyc(1);
    check("a5_rd_off", tri_t, 0);

    // 3. 3C to TC, read TC, then both selects
    send_bits(16'h003C, 8);
    pi_latch(1'b1);
    check("3c_tc", tc_q, 8'h3C);
    check("3c_td_kept", td_q, 8'hA5);
    ti_rd_tc = 1'b1;
    wait_cyc(1);
    check("3c_rd_tri_t", tri_t, 1);
    check("3c_rd_tri_i", tri_i, 8'h3C);
    ti_rd_td = 1'b1;
    wait_cyc(1);
    check("both_tri_t", tri_t, 0);
    check("both_tri_i", tri_i, 8'h00);
    ti_rd_td = 1'b0;
    ti_rd_tc = 1'b0;
    wait_cyc(1);

    // 4. Short frame, saturated long frame, then a good frame clears the flag
    p0 = pulse_cnt;
    send_bits(16'h0015, 5);
    pi_latch(1'b0);
    check("short_err", frame_err, 1);
    check("short_td", td_q, 8'hA5);
    check("short_tc", tc_q, 8'h3C);
    check("short_no_pulse", pulse_cnt - p0, 0);
    send_bits(16'h02AA, 10);
    pi_latch(1'b1);
    check("long_err", frame_err, 1);
    check("long_tc", tc_q, 8'h3C);
    check("long_no_pulse", pulse_cnt - p0, 0);
    send_bits(16'h00FF, 8);
    pi_latch(1'b0);
    check("ff_td", td_q, 8'hFF);
    check("ff_err_clear", frame_err, 0);
    check("ff_pulse", pulse_cnt - p0, 1);

    // 5. Latch 5A into TD while TD is being read
    send_bits(16'h00A5, 8);
    pi_latch(1'b0);
    check("a5_again_td", td_q, 8'hA5);
    ti_rd_td = 1'b1;
    wait_cyc(2);
    check("hold_tri_i_old", tri_i, 8'hA5);
    low0 = tri_low;
    send_bits(16'h005A, 8);
    pi_latch(1'b0);
    low1 = tri_low;
    check("hold_tri_t_stays", low1 - low0, 0);
    check("hold_td_new", td_q, 8'h5A);
    check("hold_tri_i_new", tri_i, 8'h5A);
    check("hold_tri_lag", tri_chg - td_chg, 1);

    // 6. Reset after 4 bits, asynchronously between clk edges
    send_bits(16'h000F, 4);
    check("pre_rst_tri_t", tri_t, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async_tri_t", tri_t, 0);
    check("rst_async_tri_i", tri_i, 8'h00);
    check("rst_async_td", td_q, 8'h00);
    check("rst_async_tc", tc_q, 8'h00);
    check("rst_async_pulse", latch_pulse, 0);
    check("rst_async_err", frame_err, 0);
    ti_rd_td = 1'b0;
    wait_cyc(3);
    check("rst_hold_tri_t", tri_t, 0);
    reset_n = 1'b1;
    wait_cyc(5);
    p1 = pulse_cnt;
    send_bits(16'h0081, 8);
    pi_latch(1'b1);
    check("post_rst_tc", tc_q, 8'h81);
    check("post_rst_td", td_q, 8'h00);
    check("post_rst_err", frame_err, 0);
    check("post_rst_pulse", pulse_cnt - p1, 1);

    check("pulse_single_cycle", pulse_max_run, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
